// File: rtl/mcu_bus_pkg.sv
// Shared MCU bus definitions: in-flight tag encoding and default bus widths.
package mcu_bus_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 8;

  typedef logic [1:0] tag_t;

  localparam tag_t TAG_NONE = 2'd0;
  localparam tag_t TAG_CPU  = 2'd1;
  localparam tag_t TAG_DBG  = 2'd2;

endpackage

// File: rtl/rom_arb_resp_hold.sv
// Per-port response path: valid pulse while the in-flight tag matches this port,
// plus a hold register so rdata keeps the last byte returned between pulses.
module rom_arb_resp_hold
  import mcu_bus_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hit,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= '0;
    end else if (hit) begin
      hold <= rom_data;
    end
  end

  // The live ROM byte is forwarded in the return cycle itself, so no extra latency.
  assign rvalid = hit;
  assign rdata  = hit ? rom_data : hold;

endmodule

// File: rtl/rom_arbiter.sv
// Two-port arbiter for the synchronous program ROM (CPU fetch vs debug readback).
// Build option ROM_ARB_RR_EN swaps CPU priority + starvation escape for round-robin.
module rom_arbiter
  import mcu_bus_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int DBG_MAX_WAIT = 4
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic                  CPU_REQ,
  input  logic [ADDR_WIDTH-1:0] CPU_ADDR,
  output logic                  CPU_GNT,
  output logic                  CPU_RVALID,
  output logic [DATA_WIDTH-1:0] CPU_RDATA,
  input  logic                  DBG_REQ,
  input  logic [ADDR_WIDTH-1:0] DBG_ADDR,
  output logic                  DBG_GNT,
  output logic                  DBG_RVALID,
  output logic [DATA_WIDTH-1:0] DBG_RDATA,
  output logic [ADDR_WIDTH-1:0] ROM_ADDR,
  input  logic [DATA_WIDTH-1:0] ROM_DATA
);

  logic                  dbg_pri;
  logic                  cpu_win;
  logic                  dbg_win;
  tag_t                  tag;
  logic [ADDR_WIDTH-1:0] last_addr;

`ifdef ROM_ARB_RR_EN
  // Reset value "DBG won last" makes CPU the first winner of a contested cycle.
  logic last_dbg;

  assign dbg_pri = ~last_dbg;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      last_dbg <= 1'b1;
    end else if (cpu_win) begin
      last_dbg <= 1'b0;
    end else if (dbg_win) begin
      last_dbg <= 1'b1;
    end
  end
`else
  localparam logic [3:0] MAX_WAIT = 4'(DBG_MAX_WAIT);

  logic [3:0] starve_cnt;

  assign dbg_pri = (starve_cnt >= MAX_WAIT);

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      starve_cnt <= 4'd0;
    end else if (!DBG_REQ || dbg_win) begin
      starve_cnt <= 4'd0;
    end else if (starve_cnt < MAX_WAIT) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`endif

  // Gating with RESETN keeps grants and ROM_ADDR at zero while reset is held.
  assign cpu_win = RESETN & CPU_REQ & (~DBG_REQ | ~dbg_pri);
  assign dbg_win = RESETN & DBG_REQ & (~CPU_REQ | dbg_pri);

  assign CPU_GNT  = cpu_win;
  assign DBG_GNT  = dbg_win;
  assign ROM_ADDR = cpu_win ? CPU_ADDR : (dbg_win ? DBG_ADDR : last_addr);

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      last_addr <= '0;
      tag       <= TAG_NONE;
    end else begin
      if (cpu_win || dbg_win) begin
        last_addr <= ROM_ADDR;
      end
      tag <= cpu_win ? TAG_CPU : (dbg_win ? TAG_DBG : TAG_NONE);
    end
  end

  rom_arb_resp_hold #(.DATA_WIDTH(DATA_WIDTH)) u_cpu_resp (
    .clk      (CLK),
    .rst_n    (RESETN),
    .hit      (tag == TAG_CPU),
    .rom_data (ROM_DATA),
    .rvalid   (CPU_RVALID),
    .rdata    (CPU_RDATA)
  );

  rom_arb_resp_hold #(.DATA_WIDTH(DATA_WIDTH)) u_dbg_resp (
    .clk      (CLK),
    .rst_n    (RESETN),
    .hit      (tag == TAG_DBG),
    .rom_data (ROM_DATA),
    .rvalid   (DBG_RVALID),
    .rdata    (DBG_RDATA)
  );

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: emulated ROM, behavioural reference model with a
// per-cycle compare, and directed scenarios with literal expectations.
module tb_rom_arbiter;

  localparam int AW       = 8;
  localparam int DW       = 8;
  localparam int MAX_WAIT = 4;

  logic          CLK;
  logic          RESETN;
  logic          CPU_REQ;
  logic [AW-1:0] CPU_ADDR;
  logic          CPU_GNT;
  logic          CPU_RVALID;
  logic [DW-1:0] CPU_RDATA;
  logic          DBG_REQ;
  logic [AW-1:0] DBG_ADDR;
  logic          DBG_GNT;
  logic          DBG_RVALID;
  logic [DW-1:0] DBG_RDATA;
  logic [AW-1:0] ROM_ADDR;
  logic [DW-1:0] ROM_DATA;

  rom_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DBG_MAX_WAIT(MAX_WAIT)) dut (
    .CLK        (CLK),
    .RESETN     (RESETN),
    .CPU_REQ    (CPU_REQ),
    .CPU_ADDR   (CPU_ADDR),
    .CPU_GNT    (CPU_GNT),
    .CPU_RVALID (CPU_RVALID),
    .CPU_RDATA  (CPU_RDATA),
    .DBG_REQ    (DBG_REQ),
    .DBG_ADDR   (DBG_ADDR),
    .DBG_GNT    (DBG_GNT),
    .DBG_RVALID (DBG_RVALID),
    .DBG_RDATA  (DBG_RDATA),
    .ROM_ADDR   (ROM_ADDR),
    .ROM_DATA   (ROM_DATA)
  );

  // ---------------- clock / reset / ROM ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [DW-1:0] rom [256];

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'((i * 7 + 3) & 255);
    rom[8'h10] = 8'hA5;
  end

  initial ROM_DATA = '0;
  always @(posedge CLK) ROM_DATA <= rom[ROM_ADDR];

  // ---------------- counters / check ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model + compare ----------------
  // Each entry: {owner(2): 0 none, 1 cpu, 2 dbg, data(DW)} for the response due next cycle.
  logic [DW+1:0] exp_q[$];
  logic [DW-1:0] m_hold_c, m_hold_d;
  logic [AW-1:0] m_last_addr;
  int            m_denials;
  bit            m_last_dbg;

  always @(negedge CLK) begin
    logic [DW+1:0] e;
    bit            cw, dw;
    logic [AW-1:0] a;
    if (!RESETN) begin
      check("rst_cpu_gnt", CPU_GNT, 0);
      check("rst_dbg_gnt", DBG_GNT, 0);
      check("rst_cpu_rvalid", CPU_RVALID, 0);
      check("rst_dbg_rvalid", DBG_RVALID, 0);
      check("rst_cpu_rdata", CPU_RDATA, 0);
      check("rst_dbg_rdata", DBG_RDATA, 0);
      check("rst_rom_addr", ROM_ADDR, 0);
      exp_q.delete();
      exp_q.push_back('0);
      m_hold_c = '0; m_hold_d = '0; m_last_addr = '0;
      m_denials = 0; m_last_dbg = 1'b1;
    end else begin
      if (exp_q.size() == 0) begin
        check("model_queue_empty", 1, 0);
        e = '0;
      end else begin
        e = exp_q.pop_front();
      end
      if (e[DW+1:DW] == 2'd1) m_hold_c = e[DW-1:0];
      if (e[DW+1:DW] == 2'd2) m_hold_d = e[DW-1:0];
      check("cpu_rvalid", CPU_RVALID, (e[DW+1:DW] == 2'd1));
      check("dbg_rvalid", DBG_RVALID, (e[DW+1:DW] == 2'd2));
      check("cpu_rdata", CPU_RDATA, m_hold_c);
      check("dbg_rdata", DBG_RDATA, m_hold_d);

`ifdef ROM_ARB_RR_EN
      dw = DBG_REQ && (!CPU_REQ || !m_last_dbg);
`else
      dw = DBG_REQ && (!CPU_REQ || m_denials >= MAX_WAIT);
`endif
      cw = CPU_REQ && !dw;
      if (DBG_REQ && !dw) m_denials++;
      else m_denials = 0;
      if (cw) m_last_dbg = 1'b0;
      if (dw) m_last_dbg = 1'b1;

      a = cw ? CPU_ADDR : (dw ? DBG_ADDR : m_last_addr);
      m_last_addr = a;
      check("cpu_gnt", CPU_GNT, cw);
      check("dbg_gnt", DBG_GNT, dw);
      check("rom_addr", ROM_ADDR, a);
      exp_q.push_back({(cw ? 2'd1 : (dw ? 2'd2 : 2'd0)), rom[a]});
    end
  end

  // ---------------- drivers ----------------
  // Drives one cycle of requests and returns at that cycle's falling edge.
  task automatic cyc(input bit cr, input logic [AW-1:0] ca, input bit dr, input logic [AW-1:0] da);
    @(posedge CLK); #1;
    CPU_REQ = cr; CPU_ADDR = ca; DBG_REQ = dr; DBG_ADDR = da;
    @(negedge CLK);
  endtask

  task automatic apply_reset();
    @(posedge CLK); #1;
    RESETN = 1'b0; CPU_REQ = 1'b0; DBG_REQ = 1'b0;
    @(posedge CLK); #1;
    RESETN = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  logic [9:0]  g;
  logic [15:0] cr_pat;
  logic [15:0] dr_pat;

  initial begin
    RESETN = 1'b0; CPU_REQ = 1'b0; CPU_ADDR = '0; DBG_REQ = 1'b0; DBG_ADDR = '0;
    repeat (2) @(posedge CLK);
    #1 RESETN = 1'b1;

    // single CPU read
    cyc(1, 8'h10, 0, 8'h00);
    check("t1_cpu_gnt", CPU_GNT, 1);
    check("t1_rom_addr", ROM_ADDR, 8'h10);
    cyc(0, 8'h00, 0, 8'h00);
    check("t1_cpu_rvalid", CPU_RVALID, 1);
    check("t1_cpu_rdata", CPU_RDATA, 8'hA5);
    check("t1_dbg_rvalid", DBG_RVALID, 0);

    // both requesting continuously from a fresh reset
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      cyc(1, 8'(8'h40 + i), 1, 8'(8'h80 + i));
      g[i] = DBG_GNT;
    end
`ifdef ROM_ARB_RR_EN
    check("t2_grant_pattern", g, 10'h2AA);
`else
    check("t2_grant_pattern", g, 10'h210);
`endif
    cyc(0, 8'h00, 0, 8'h00);

    // alternating owners, back to back
    cyc(1, 8'h00, 0, 8'h00);
    cyc(0, 8'h00, 1, 8'h01);
    check("t3_cpu_rvalid", CPU_RVALID, 1);
    check("t3_cpu_rdata0", CPU_RDATA, 8'h03);
    cyc(1, 8'h02, 0, 8'h00);
    check("t3_dbg_rvalid", DBG_RVALID, 1);
    check("t3_dbg_rdata1", DBG_RDATA, 8'h0A);
    check("t3_cpu_hold", CPU_RDATA, 8'h03);
    cyc(0, 8'h00, 0, 8'h00);
    check("t3_cpu_rdata2", CPU_RDATA, 8'h11);
    check("t3_dbg_hold", DBG_RDATA, 8'h0A);

    // reset with a read in flight
    cyc(1, 8'h20, 0, 8'h00);
    check("t4_cpu_gnt", CPU_GNT, 1);
    @(posedge CLK); #1;
    RESETN = 1'b0; CPU_REQ = 1'b0;
    @(negedge CLK);
    check("t4_no_rvalid", CPU_RVALID, 0);
    check("t4_rdata_clr", CPU_RDATA, 0);
    check("t4_rom_addr", ROM_ADDR, 0);
    @(posedge CLK); #1;
    RESETN = 1'b1;
    cyc(0, 8'h00, 1, 8'h05);
    check("t4_dbg_gnt", DBG_GNT, 1);
    cyc(0, 8'h00, 0, 8'h00);
    check("t4_dbg_rdata", DBG_RDATA, 8'h26);

    // idle after a read keeps the address
    cyc(0, 8'h00, 1, 8'h33);
    cyc(0, 8'h00, 0, 8'h00);
    check("t5_rom_addr_a", ROM_ADDR, 8'h33);
    cyc(0, 8'h00, 0, 8'h00);
    check("t5_rom_addr_b", ROM_ADDR, 8'h33);
    check("t5_gnts", {CPU_GNT, DBG_GNT}, 2'b00);
    check("t5_rvalids", {CPU_RVALID, DBG_RVALID}, 2'b00);

    // mixed directed patterns, checked by the model
    cr_pat = 16'b1011_0111_1110_0101;
    dr_pat = 16'b1101_1111_0110_0011;
    for (int i = 0; i < 16; i++) begin
      cyc(cr_pat[i], 8'(i * 17), dr_pat[i], 8'(255 - i * 13));
    end
    cyc(0, 8'h00, 0, 8'h00);
    cyc(0, 8'h00, 0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
Name: rom_arbiter

Overview:
- Shares the single synchronous program ROM between two requesters: the CPU instruction/data fetch port and a debug/readback port used by the host link for ROM dumps and checksums.
- Arbitrates per cycle, drives the ROM address, and tracks the one-cycle ROM read latency.
- Routes each returned byte, with a valid pulse, to the requester that issued the read.
- Sits between the MCU core/debug bridge and the ROM on the MCU bus.

Parameters:
ADDR_WIDTH, 8, ROM address width; ROM depth is 2**ADDR_WIDTH bytes.
DATA_WIDTH, 8, ROM word width.
DBG_MAX_WAIT, 4, consecutive cycles DBG may be denied before it is forced to win one grant; range 1..15.

Ports:
CLK  in  1  system clock, all logic on rising edge
RESETN  in  1  asynchronous, active-low reset
CPU_REQ  in  1  CPU read request, held until granted
CPU_ADDR  in  ADDR_WIDTH  CPU read address
CPU_GNT  out  1  CPU request accepted this cycle (combinational)
CPU_RVALID  out  1  CPU read data valid (one-cycle pulse)
CPU_RDATA  out  DATA_WIDTH  CPU read data, holds the last value returned
DBG_REQ  in  1  debug read request, held until granted
DBG_ADDR  in  ADDR_WIDTH  debug read address
DBG_GNT  out  1  debug request accepted this cycle (combinational)
DBG_RVALID  out  1  debug read data valid (one-cycle pulse)
DBG_RDATA  out  DATA_WIDTH  debug read data, holds the last value returned
ROM_ADDR  out  ADDR_WIDTH  address to ROM, sampled by the ROM at the clock edge
ROM_DATA  in  DATA_WIDTH  registered ROM output, valid one cycle after the address

Behaviour:
- Reset (RESETN low, asynchronous):
  - GNTs forced to 0 and RVALIDs cleared to 0.
  - RDATA hold registers cleared to 0.
  - last_addr register and ROM_ADDR are 0.
  - In-flight tag set to NONE; starvation counter cleared to 0.
  - A read in flight when reset asserts is dropped: no RVALID follows.
- Arbitration (combinational, cycle N):
  - At most one GNT is high.
  - Only one requester: it wins.
  - Both requesting: CPU wins, unless the starvation counter has reached DBG_MAX_WAIT, in which case DBG wins.
- ROM address: the winner's address goes to ROM_ADDR. With no grant, ROM_ADDR = last_addr, which updates on every grant.
- In-flight tag: a register with values NONE / CPU / DBG, loaded at each edge with the cycle-N winner (NONE if no grant).
- Response (cycle N+1): tag == X gives X_RVALID = 1 and X_RDATA = ROM_DATA. X_RDATA is also loaded into that port's hold register; at all other times X_RDATA shows the hold register.
- Latency and throughput: grant to RVALID is exactly 1 cycle. Back-to-back grants every cycle are allowed, giving one read per cycle sustained, with alternating owners routed correctly.
- Starvation counter (4 bit):
  - Increments when DBG_REQ is high and DBG is not granted.
  - Clears on any DBG grant or when DBG_REQ is low.
  - Saturates at DBG_MAX_WAIT.
- A requester dropping REQ before GNT is legal; nothing is issued for it.
- Address wrap: none; the address passes straight through.

Optional Feature:
- ROM_ARB_RR_EN defined: fixed priority and the starvation counter are replaced by round-robin. A 1-bit last-winner register is updated on each grant. When both requesters are asking, the port that did not win last is granted; after reset, CPU is preferred first. DBG_MAX_WAIT is ignored.
- ROM_ARB_RR_EN undefined: CPU priority with starvation escape, as described above.

Decomposition:
- Shared package (mcu_bus_pkg) holds:
  - Tag encoding constants: TAG_NONE = 2'd0, TAG_CPU = 2'd1, TAG_DBG = 2'd2.
  - Default ADDR_WIDTH and DATA_WIDTH constants.
- One natural sub-module: rom_arb_resp_hold, a per-port RVALID register plus RDATA hold/mux, instantiated twice.

Test Plan:
- Reset, then CPU_REQ with CPU_ADDR = 0x10 for one cycle, ROM[0x10] = 0xA5 -> CPU_GNT = 1 that cycle; next cycle CPU_RVALID = 1 and CPU_RDATA = 0xA5; DBG_RVALID stays 0.
- CPU and DBG both requesting continuously, DBG_MAX_WAIT = 4 -> CPU granted 4 cycles, DBG on the 5th, pattern repeats. Every RVALID lands exactly 1 cycle after its grant with the matching byte.
- Alternate every cycle: CPU 0x00, DBG 0x01, CPU 0x02 -> RVALIDs alternate CPU/DBG/CPU with ROM[0x00], ROM[0x01], ROM[0x02]. Hold registers keep values between pulses.
- Grant CPU at 0x20, assert RESETN low in the following cycle -> no CPU_RVALID, all outputs 0 immediately. After release, the first read works normally.
- No requests after a read at 0x33 -> ROM_ADDR remains 0x33, both GNTs 0, no RVALID.
- With ROM_ARB_RR_EN defined, both requesting -> grants go CPU, DBG, CPU, DBG… starting with CPU after reset.
